mux_rr_arb: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output. It runs in one of two modes. In fixed-select mode it behaves as a sequential 4:1-style mux steered by `sel`. In round-robin mode it arbitrates fairly among all valid channels. It sits between independent producers and a single consumer, and is the general successor to the combinational 4:1 mux.

---
 rtl/mux_rr_pkg.sv | 14 +
 rtl/rr_pick_n.sv | 17 +
 rtl/mux_rr_arb.sv | 50 +++++
 tb/tb_mux_rr_arb.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared mode constants and round-robin search helper
package mux_rr_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int MAX_CH = 32;
  localparam int IDX_W = 5;
  function automatic logic [IDX_W:0] rr_pick(input logic [MAX_CH-1:0] valid, input logic [IDX_W-1:0] ptr, input int n);
    logic [IDX_W:0] r;
    r = '0;
    for (int k = MAX_CH; k >= 1; k--)
      if (k <= n && valid[IDX_W'((int'(ptr) + k) % n)]) r = {1'b1, IDX_W'((int'(ptr) + k) % n)};
    return r;
  endfunction
endpackage

// File: rtl/rr_pick_n.sv
// rr_pick_n: first valid channel after ptr, wrapping modulo N_CH
module rr_pick_n
  import mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] valid,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] idx
);
  logic [IDX_W:0] r;
  assign r = rr_pick(MAX_CH'(valid), IDX_W'(ptr), N_CH);
  assign found = r[IDX_W];
  assign idx = CH_W'(r[IDX_W-1:0]);
endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: registered N-channel mux with fixed-select or round-robin arbitration
module mux_rr_arb
  import mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [CH_W-1:0]   sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [DATA_W-1:0] in_data [N_CH],
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_chan,
  input  logic              out_ready
);
  logic [CH_W-1:0] ptr, rr_idx, g;
  logic rr_found, fx_found, found, load, xfer;
  rr_pick_n #(.N_CH(N_CH)) u_pick (
    .valid(in_valid),
    .ptr  (ptr),
    .found(rr_found),
    .idx  (rr_idx)
  );
  assign fx_found = (int'(sel) < N_CH) ? in_valid[sel] : 1'b0;
  assign found = (mode == MODE_RR) ? rr_found : fx_found;
  assign g = (mode == MODE_RR) ? rr_idx : sel;
  assign load = !out_valid || out_ready;
  assign xfer = !rst && load && found;
  assign in_ready = xfer ? N_CH'(1) << g : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      ptr <= CH_W'(N_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= in_data[g];
      out_chan <= g;
      ptr <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: directed stimulus checked against a behavioural arbiter model
module tb_mux_rr_arb;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, mode, out_ready, out_valid;
  logic [1:0] sel, out_chan;
  logic [N-1:0] in_valid, in_ready;
  logic [W-1:0] in_data [N];
  logic [W-1:0] out_data;
  int total = 0;
  int passed = 0;
  bit m_on = 1'b0;
  bit m_valid;
  int m_data, m_chan, m_ptr;

  always #5 clk = ~clk;

  mux_rr_arb #(.N_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int grant();
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++)
      if (in_valid[2'((m_ptr + k) % N)]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int exp_ready();
    int g = grant();
    return (!rst && (!m_valid || out_ready) && g >= 0) ? (1 << g) : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on <= 1'b1;
      m_valid <= 1'b0;
      m_data <= 0;
      m_chan <= 0;
      m_ptr <= N - 1;
    end else if (exp_ready() != 0) begin
      m_valid <= 1'b1;
      m_data <= int'(in_data[2'(grant())]);
      m_chan <= grant();
      m_ptr <= grant();
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_in_ready", int'(in_ready), exp_ready());
      chk("model_out_valid", int'(out_valid), int'(m_valid));
      chk("model_out_data", int'(out_data), m_data);
      chk("model_out_chan", int'(out_chan), m_chan);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = '0; out_ready = 1'b1;
    in_data[0] = 8'hA0; in_data[1] = 8'hB1; in_data[2] = 8'hC2; in_data[3] = 8'hD3;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    in_valid = 4'b1111;
    #1 chk("rst_in_ready", int'(in_ready), 0);
    cyc();
    rst = 1'b0;
    #1 chk("fix_sel2_ready", int'(in_ready), 4'b0100);
    cyc();
    chk("fix_sel2_valid", int'(out_valid), 1);
    chk("fix_sel2_data", int'(out_data), 8'hC2);
    chk("fix_sel2_chan", int'(out_chan), 2);
    sel = 2'd1; in_valid = 4'b1101;
    #1 chk("fix_sel1_none", int'(in_ready), 0);
    cyc();
    chk("fix_drain_valid", int'(out_valid), 0);
    chk("fix_drain_hold", int'(out_data), 8'hC2);
    in_valid[1] = 1'b1; in_data[1] = 8'h5A;
    #1 chk("fix_sel1_ready", int'(in_ready), 4'b0010);
    cyc();
    chk("fix_sel1_data", int'(out_data), 8'h5A);
    chk("fix_sel1_chan", int'(out_chan), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_data[1] = 8'hB1; mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_all_chan", int'(out_chan), i % 4);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_1010_chan", int'(out_chan), (i % 2) ? 3 : 1);
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_0010_chan", int'(out_chan), 1);
    end
    mode = 1'b0; sel = 2'd0; in_data[0] = 8'h77; in_valid = 4'b0001;
    cyc();
    chk("bp_load_data", int'(out_data), 8'h77);
    out_ready = 1'b0; in_data[0] = 8'h88;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready_low", int'(in_ready), 0);
      cyc();
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_data", int'(out_data), 8'h77);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", int'(in_ready), 4'b0001);
    cyc();
    chk("bp_release_data", int'(out_data), 8'h88);
    in_data[0] = 8'hA0; mode = 1'b1; in_valid = 4'b1111; rst = 1'b1;
    cyc();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_chan", int'(out_chan), 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_chan", int'(out_chan), 0);
    chk("post_rst_data", int'(out_data), 8'hA0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
